// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write buffer between a single-cycle core data port and a slower
//   data memory with a request/acknowledge write handshake. Core stores are
//   queued in a circular FIFO and retired one at a time. Loads are forwarded
//   from the newest matching buffered store, otherwise they come from memory.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   MemWrite   core store request
//   DataAdr    core byte address (loads and stores)
//   WriteData  core store data
//   ReadData   load data to the core (combinational)
//   Stall      store not accepted this cycle (FIFO full)
//   mem_we     memory write request
//   mem_adr    memory write address (head entry)
//   mem_wd     memory write data (head entry)
//   mem_ack    memory accepted the write
//   mem_radr   memory read address (= DataAdr)
//   mem_rd     memory read data
//   Empty      no entries buffered
//   Count      number of buffered entries
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [AW-1:0]            DataAdr,
    input  logic [DW-1:0]            WriteData,
    output logic [DW-1:0]            ReadData,
    output logic                     Stall,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_adr,
    output logic [DW-1:0]            mem_wd,
    input  logic                     mem_ack,
    output logic [AW-1:0]            mem_radr,
    input  logic [DW-1:0]            mem_rd,
    output logic                     Empty,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   head, tail;
    logic [AW-3:0]   adr_q  [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];

    logic            full;
    logic            push, pop;
    logic            fwd_hit;
    logic [DW-1:0]   fwd_data;

    assign full  = (Count == CW'(DEPTH));
    assign Empty = (Count == '0);
    assign Stall = MemWrite & full;
    assign push  = MemWrite & ~full;
    assign pop   = (state == WRITE) & mem_ack;

    // Drain FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Drain FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Count != '0) state_nxt = WRITE;
            WRITE:   if (mem_ack)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Drain FSM: outputs; address/data forced to zero outside WRITE so the
    // memory side reads zero immediately on reset
    always_comb begin
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;
        if (state == WRITE) begin
            mem_we  = 1'b1;
            mem_adr = {adr_q[head], 2'b00};
            mem_wd  = data_q[head];
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            Count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

    // Entry storage; validity is implied by position between head and tail
    always_ff @(posedge clk) begin
        if (push) begin
            adr_q[tail]  <= DataAdr[AW-1:2];
            data_q[tail] <= WriteData;
        end
    end

    // Forwarding: walk oldest to newest so the newest match wins
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if ((CW'(k) < Count) && (adr_q[idx] == DataAdr[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign ReadData = fwd_hit ? fwd_data : mem_rd;
    assign mem_radr = DataAdr;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic        mem_ack;
    logic [31:0] mem_radr;
    logic [31:0] mem_rd;
    logic        Empty;
    logic [2:0]  Count;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_ack(mem_ack), .mem_radr(mem_radr), .mem_rd(mem_rd),
        .Empty(Empty), .Count(Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of buffered {adr, data}, a busy flag meaning
    // "a memory write request is outstanding", and a log of retired writes.
    logic [63:0] mq[$];
    logic [63:0] wlog[$];
    logic        busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle; called just after a falling edge.
    task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] wd,
                       input logic ack, input logic [31:0] rd,
                       output logic acc, output logic [31:0] rdata);
        logic [31:0] exp_rd;
        logic        popped;
        MemWrite = mw; DataAdr = a; WriteData = wd; mem_ack = ack; mem_rd = rd;
        #1;
        exp_rd = rd;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i][63:34] == a[31:2]) exp_rd = mq[i][31:0];
        chk("count", 64'(Count), 64'(mq.size()));
        chk("empty", 64'(Empty), 64'(mq.size() == 0));
        chk("stall", 64'(Stall), 64'(mw && mq.size() == DEPTH));
        chk("readdata", 64'(ReadData), 64'(exp_rd));
        chk("mem_radr", 64'(mem_radr), 64'(a));
        chk("mem_we", 64'(mem_we), 64'(busy));
        if (busy && mq.size() > 0) begin
            chk("mem_adr", 64'(mem_adr), 64'({mq[0][63:34], 2'b00}));
            chk("mem_wd", 64'(mem_wd), 64'(mq[0][31:0]));
        end
        rdata  = ReadData;
        acc    = mw && (mq.size() < DEPTH);
        popped = busy && ack;
        @(posedge clk);
        if (busy) busy = !ack;
        else      busy = (mq.size() > 0);
        if (popped) begin
            wlog.push_back(mq[0]);
            void'(mq.pop_front());
        end
        if (acc) mq.push_back({a, wd});
        @(negedge clk);
    endtask

    logic        acc;
    logic [31:0] rdv;
    logic [31:0] adrs[10];
    int          n;
    int          guard;

    initial begin
        reset = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
        mem_ack = 1'b0; mem_rd = '0;
        mq.delete(); wlog.delete(); busy = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_count", 64'(Count), 64'd0);
        chk("rst_empty", 64'(Empty), 64'd1);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_adr", 64'(mem_adr), 64'd0);
        chk("rst_wd", 64'(mem_wd), 64'd0);
        chk("rst_stall", 64'(Stall), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single store, ack tied high: one write of 400/7, then empty
        cyc(1'b1, 32'd400, 32'd7, 1'b1, 32'd0, acc, rdv);
        chk("t1_we_n1", 64'(mem_we), 64'd0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 32'd0, acc, rdv);
        chk("t1_we", 64'(mem_we), 64'd1);
        chk("t1_adr", 64'(mem_adr), 64'd400);
        chk("t1_wd", 64'(mem_wd), 64'd7);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 32'd0, acc, rdv);
        chk("t1_we_low", 64'(mem_we), 64'd0);
        chk("t1_empty", 64'(Empty), 64'd1);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 32'd0, acc, rdv);
        chk("t1_nwrites", 64'(wlog.size()), 64'd1);
        chk("t1_entry", wlog[0], {32'd400, 32'd7});
        wlog.delete();

        // Fill and stall
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'd400 + 32'(4 * i), 32'(100 + i), 1'b0, 32'd0, acc, rdv);
            if (i == 4) chk("t2_stall_5th", 64'(acc), 64'd0);
        end
        chk("t2_count_max", 64'(Count), 64'd4);
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 20) begin
            cyc(1'b1, 32'd416, 32'd104, 1'b1, 32'd0, acc, rdv);
            guard++;
        end
        chk("t2_416_accepted", 64'(acc), 64'd1);
        guard = 0;
        while ((mq.size() > 0 || busy) && guard < 50) begin
            cyc(1'b0, 32'd0, 32'd0, 1'b1, 32'd0, acc, rdv);
            guard++;
        end
        chk("t2_drained", 64'(mq.size() == 0 && !busy), 64'd1);
        chk("t2_nwrites", 64'(wlog.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            if (i < wlog.size())
                chk("t2_order", 64'(wlog[i][63:32]), 64'(400 + 4 * i));
        wlog.delete();

        // Forwarding, newest wins; miss falls through to mem_rd
        cyc(1'b1, 32'd436, 32'd1, 1'b0, 32'd0, acc, rdv);
        cyc(1'b1, 32'd436, 32'd1024, 1'b0, 32'd0, acc, rdv);
        cyc(1'b0, 32'd436, 32'd0, 1'b0, 32'd5, acc, rdv);
        chk("t3_fwd_newest", 64'(rdv), 64'd1024);
        cyc(1'b0, 32'd438, 32'd0, 1'b0, 32'd5, acc, rdv);
        chk("t3_fwd_bytebits", 64'(rdv), 64'd1024);
        cyc(1'b0, 32'd440, 32'd0, 1'b0, 32'd5, acc, rdv);
        chk("t3_miss", 64'(rdv), 64'd5);

        // Simultaneous push and pop with Count=2 in WRITE
        chk("t4_pre_count", 64'(Count), 64'd2);
        chk("t4_pre_we", 64'(mem_we), 64'd1);
        cyc(1'b1, 32'd444, 32'd99, 1'b1, 32'd0, acc, rdv);
        chk("t4_count", 64'(Count), 64'd2);
        cyc(1'b0, 32'd444, 32'd0, 1'b0, 32'd0, acc, rdv);
        chk("t4_tail_fwd", 64'(rdv), 64'd99);
        guard = 0;
        while ((mq.size() > 0 || busy) && guard < 50) begin
            cyc(1'b0, 32'd0, 32'd0, 1'b1, 32'd0, acc, rdv);
            guard++;
        end
        chk("t4_nwrites", 64'(wlog.size()), 64'd3);
        if (wlog.size() == 3) begin
            chk("t4_w0", wlog[0], {32'd436, 32'd1});
            chk("t4_w1", wlog[1], {32'd436, 32'd1024});
            chk("t4_w2", wlog[2], {32'd444, 32'd99});
        end
        wlog.delete();

        // Wrap-around: 10 stores, random ack
        for (int i = 0; i < 10; i++) adrs[i] = {$urandom_range(0, 255), 2'b00};
        n = 0;
        guard = 0;
        while (n < 10 && guard < 400) begin
            cyc(1'b1, adrs[n], 32'(n), 1'($urandom_range(0, 1)),
                $urandom, acc, rdv);
            if (acc) n++;
            guard++;
        end
        chk("t5_all_pushed", 64'(n), 64'd10);
        guard = 0;
        while ((mq.size() > 0 || busy) && guard < 400) begin
            cyc(1'b0, {$urandom_range(0, 255), 2'b00}, 32'd0,
                1'($urandom_range(0, 1)), $urandom, acc, rdv);
            guard++;
        end
        chk("t5_nwrites", 64'(wlog.size()), 64'd10);
        for (int i = 0; i < 10; i++)
            if (i < wlog.size())
                chk("t5_order", wlog[i], {adrs[i], 32'(i)});
        wlog.delete();

        // Async reset mid-write
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 32'd500 + 32'(4 * i), 32'(i + 50), 1'b0, 32'd0, acc, rdv);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, acc, rdv);
        chk("t6_pre_count", 64'(Count), 64'd3);
        chk("t6_pre_we", 64'(mem_we), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_we_async", 64'(mem_we), 64'd0);
        chk("t6_count_async", 64'(Count), 64'd0);
        chk("t6_empty_async", 64'(Empty), 64'd1);
        chk("t6_adr_async", 64'(mem_adr), 64'd0);
        mq.delete(); busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 32'd500, 32'd0, 1'b1, 32'd77, acc, rdv);
        chk("t6_no_writes", 64'(wlog.size()), 64'd0);
        chk("t6_no_fwd", 64'(rdv), 64'd77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the single-cycle core's data port and a slower data memory that uses a ready/acknowledge handshake.
- Captures core stores (MemWrite, DataAdr, WriteData) into a FIFO and retires them to memory one at a time.
- Forwards buffered store data to core loads so that reads return the most recent value.
- Stalls the core only when the FIFO is full.

Parameters:
- DEPTH, 4, number of store entries; power of two, 2..16.
- AW, 32, address width in bits.
- DW, 32, data width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemWrite  input  1  core store request this cycle.
- DataAdr  input  AW  core byte address, used for both loads and stores.
- WriteData  input  DW  core store data.
- ReadData  output  DW  load data returned to the core (combinational).
- Stall  output  1  store not accepted this cycle; core must hold its PC.
- mem_we  output  1  write request to memory (registered).
- mem_adr  output  AW  write address for memory; head entry.
- mem_wd  output  DW  write data for memory; head entry.
- mem_ack  input  1  memory accepted the write; sampled at the rising edge.
- mem_radr  output  AW  read address for memory; equals DataAdr.
- mem_rd  input  DW  memory read data (combinational).
- Empty  output  1  no entries buffered.
- Count  output  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - Head pointer, tail pointer and Count are cleared to 0; all entries become invalid.
  - FSM goes to IDLE.
  - mem_we=0, mem_adr=0 and mem_wd=0 immediately.
  - Empty=1, Stall=0.
- Reset mid-operation: buffered stores are discarded, and mem_we drops without waiting for mem_ack.
- Storage: circular FIFO of {adr[AW-1:2], data}. Pointers wrap modulo DEPTH.
- Full: Count==DEPTH. Empty: Count==0.
- Push:
  - Condition: MemWrite=1 and Count<DEPTH at the rising edge.
  - Action: entry written at the tail; tail increments.
- Stall = MemWrite & (Count==DEPTH), combinational. A stalled store is not captured; the core re-presents it.
- Pop:
  - Condition: FSM in WRITE and mem_ack=1 at the rising edge.
  - Action: head increments.
- Simultaneous push and pop: Count is unchanged and both pointers advance.
- Push when full: rejected even if a pop occurs in the same cycle. Count goes to DEPTH-1 and Stall releases the following cycle.
- Drain FSM, two states:
  - IDLE: mem_we=0. If Count>0 at the edge, go to WRITE.
  - WRITE: mem_we=1, with mem_adr={head.adr,2'b00} and mem_wd=head.data held stable. On mem_ack=1, pop and go to IDLE. Otherwise stay in WRITE indefinitely.
  - Exactly one idle cycle separates consecutive memory writes.
- Store-to-memory latency:
  - Store accepted at edge N into an empty buffer → mem_we=1 after edge N+1.
  - Earliest pop is at edge N+2.
- mem_ack while in IDLE is ignored.
- Forwarding (combinational):
  - Compare DataAdr[AW-1:2] against every valid entry.
  - On a hit, ReadData = data of the newest matching entry, i.e. the one nearest the tail.
  - On a miss, ReadData = mem_rd.
  - The entry currently being written in WRITE is still valid and still forwards until it is popped.
- Address compare uses word address only; bits [1:0] are ignored (word-aligned stores only).
- Count is registered. Empty = (Count==0).

Test Plan:
- Reset then single store:
  - Stimulus: reset low for 2 cycles then high; MemWrite=1, DataAdr=400, WriteData=7 for one cycle; mem_ack tied 1.
  - Required response: mem_we rises one cycle after capture with mem_adr=400, mem_wd=7; mem_we stays high exactly 1 cycle; then Empty=1 and Count=0.
- Fill and stall:
  - Stimulus: mem_ack=0; 5 back-to-back stores to addresses 400, 404, 408, 412, 416.
  - Required response: Count reaches 4; Stall=1 during the 5th store; Count does not exceed 4.
  - Follow-up: raise mem_ack. Writes retire in the order 400, 404, 408, 412; Stall clears and the 416 store is then accepted.
- Forwarding newest wins:
  - Stimulus: mem_ack=0; store 436←1, then 436←1024, then a load of DataAdr=436 with mem_rd=5.
  - Required response: ReadData=1024.
  - Stimulus: load of 440.
  - Required response: ReadData=5 (mem_rd).
- Simultaneous push/pop:
  - Stimulus: Count=2 in WRITE; assert MemWrite and mem_ack on the same edge.
  - Required response: Count stays 2; the new entry lands at the tail; the head advances.
- Pointer wrap-around:
  - Stimulus: 10 stores with data 0..9, with mem_ack pulsing randomly.
  - Required response: the memory receives all 10 in order with no loss or duplication.
- Async reset mid-write:
  - Stimulus: in WRITE with Count=3 and mem_ack=0, drop reset between clock edges.
  - Required response: mem_we=0 immediately; Count=0, Empty=1; no writes after reset is released until a new store arrives.
